// File: rtl/rvh_l1d_pkg.sv
// Shared types and decode helpers for the L1D atomic execution controller.
package rvh_l1d_pkg;

   localparam int XLEN           = 64;
   localparam int PADDR_WIDTH    = 40;
   localparam int ROB_TAG_WIDTH  = 6;
   localparam int PREG_TAG_WIDTH = 7;
   localparam int STU_OP_WIDTH   = 5;

   // Atomic opcodes from the store unit; bit 0 set means doubleword.
   localparam logic [STU_OP_WIDTH-1:0] STU_LRW      = 5'd0;
   localparam logic [STU_OP_WIDTH-1:0] STU_LRD      = 5'd1;
   localparam logic [STU_OP_WIDTH-1:0] STU_SCW      = 5'd2;
   localparam logic [STU_OP_WIDTH-1:0] STU_SCD      = 5'd3;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPW = 5'd4;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPD = 5'd5;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDW  = 5'd6;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDD  = 5'd7;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDW  = 5'd8;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDD  = 5'd9;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOORW   = 5'd10;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOORD   = 5'd11;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORW  = 5'd12;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORD  = 5'd13;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXW  = 5'd14;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXD  = 5'd15;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINW  = 5'd16;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIND  = 5'd17;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUW = 5'd18;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUD = 5'd19;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUW = 5'd20;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUD = 5'd21;

   // Order matches the AMO opcode pairs starting at STU_AMOSWAPW.
   typedef enum logic [3:0] {
      AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
      AMO_MAX, AMO_MIN, AMO_MAXU, AMO_MINU
   } amo_alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_ALU, S_WR_REQ, S_RESP
   } amo_state_e;

   typedef struct packed {
      amo_alu_op_e alu_op;
      logic        is_word;
      logic        is_lr;
      logic        is_sc;
   } amo_dec_t;

   // Unknown opcodes fall into the LR path so they never write the bank.
   function automatic amo_dec_t amo_decode(input logic [STU_OP_WIDTH-1:0] op);
      amo_dec_t                d;
      logic [STU_OP_WIDTH-1:0] idx;
      idx       = (op - STU_AMOSWAPW) >> 1;
      d.alu_op  = AMO_SWAP;
      d.is_word = ~op[0];
      d.is_lr   = 1'b0;
      d.is_sc   = 1'b0;
      if (op == STU_LRW || op == STU_LRD) begin
         d.is_lr = 1'b1;
      end else if (op == STU_SCW || op == STU_SCD) begin
         d.is_sc = 1'b1;
      end else if (op <= STU_AMOMINUD) begin
         d.alu_op = amo_alu_op_e'(idx[3:0]);
      end else begin
         d.is_lr = 1'b1;
      end
      return d;
   endfunction

   // Value returned to the register file: word ops sign-extend the selected lane.
   function automatic logic [XLEN-1:0] load_val(input logic [XLEN-1:0] dw,
                                                input logic is_word, input logic lane);
      logic [31:0] w;
      w = lane ? dw[63:32] : dw[31:0];
      return is_word ? {{32{w[31]}}, w} : dw;
   endfunction

endpackage

// File: rtl/rvh_l1d_amo_exec_ctrl_if.sv
// Store-buffer, data-bank and ROB writeback signals of the atomic controller.
// Handshakes: a transfer happens on a rising edge where vld and rdy are both
// high; once vld is raised the sender holds vld and payload until rdy.
interface rvh_l1d_amo_exec_ctrl_if;
   import rvh_l1d_pkg::*;

   logic                      stb_amo_req_vld_i;
   logic [ROB_TAG_WIDTH-1:0]  stb_amo_req_rob_tag_i;
   logic [PREG_TAG_WIDTH-1:0] stb_amo_req_prd_i;
   logic [STU_OP_WIDTH-1:0]   stb_amo_req_opcode_i;
   logic [PADDR_WIDTH-1:0]    stb_amo_req_paddr_i;
   logic [XLEN-1:0]           stb_amo_req_data_i;
   logic                      stb_amo_req_sc_succ_i;
   logic                      stb_amo_req_rdy_o;
   logic                      bank_rd_req_vld_o;
   logic [PADDR_WIDTH-1:0]    bank_rd_req_paddr_o;
   logic                      bank_rd_req_rdy_i;
   logic                      bank_rd_resp_vld_i;
   logic [XLEN-1:0]           bank_rd_resp_data_i;
   logic                      bank_wr_req_vld_o;
   logic [PADDR_WIDTH-1:0]    bank_wr_req_paddr_o;
   logic [XLEN-1:0]           bank_wr_req_data_o;
   logic [XLEN/8-1:0]         bank_wr_req_byte_mask_o;
   logic                      bank_wr_req_rdy_i;
   logic                      amo_rob_wb_vld_o;
   logic [ROB_TAG_WIDTH-1:0]  amo_rob_wb_rob_tag_o;
   logic [PREG_TAG_WIDTH-1:0] amo_rob_wb_prd_o;
   logic [XLEN-1:0]           amo_rob_wb_data_o;
   logic                      amo_rob_wb_rdy_i;
   logic                      busy_o;
   amo_state_e                dbg_state_o;

   modport master (
      input  stb_amo_req_vld_i, stb_amo_req_rob_tag_i, stb_amo_req_prd_i,
             stb_amo_req_opcode_i, stb_amo_req_paddr_i, stb_amo_req_data_i,
             stb_amo_req_sc_succ_i, bank_rd_req_rdy_i, bank_rd_resp_vld_i,
             bank_rd_resp_data_i, bank_wr_req_rdy_i, amo_rob_wb_rdy_i,
      output stb_amo_req_rdy_o, bank_rd_req_vld_o, bank_rd_req_paddr_o,
             bank_wr_req_vld_o, bank_wr_req_paddr_o, bank_wr_req_data_o,
             bank_wr_req_byte_mask_o, amo_rob_wb_vld_o, amo_rob_wb_rob_tag_o,
             amo_rob_wb_prd_o, amo_rob_wb_data_o, busy_o, dbg_state_o
   );

   modport slave (
      output stb_amo_req_vld_i, stb_amo_req_rob_tag_i, stb_amo_req_prd_i,
             stb_amo_req_opcode_i, stb_amo_req_paddr_i, stb_amo_req_data_i,
             stb_amo_req_sc_succ_i, bank_rd_req_rdy_i, bank_rd_resp_vld_i,
             bank_rd_resp_data_i, bank_wr_req_rdy_i, amo_rob_wb_rdy_i,
      input  stb_amo_req_rdy_o, bank_rd_req_vld_o, bank_rd_req_paddr_o,
             bank_wr_req_vld_o, bank_wr_req_paddr_o, bank_wr_req_data_o,
             bank_wr_req_byte_mask_o, amo_rob_wb_vld_o, amo_rob_wb_rob_tag_o,
             amo_rob_wb_prd_o, amo_rob_wb_data_o, busy_o, dbg_state_o
   );

endinterface

// File: rtl/rvh_l1d_amo_alu.sv
// Combinational read-modify-write datapath for one atomic operation.
module rvh_l1d_amo_alu
   import rvh_l1d_pkg::*;
(
   input  logic [XLEN-1:0]   old_data,
   input  logic [XLEN-1:0]   rs2,
   input  amo_alu_op_e       alu_op,
   input  logic              is_word,
   input  logic              lane,
   output logic [XLEN-1:0]   new_data,
   output logic [XLEN/8-1:0] byte_mask
);

   logic [31:0] old_w;
   logic [31:0] rs2_w;
   logic [31:0] res_w;
   logic [63:0] res_d;

   // Word and doubleword results computed side by side; the width bit picks one.
   always_comb begin
      old_w = lane ? old_data[63:32] : old_data[31:0];
      rs2_w = rs2[31:0];
      res_w = rs2_w;
      res_d = rs2;
      case (alu_op)
         AMO_SWAP: begin res_w = rs2_w;          res_d = rs2;            end
         AMO_ADD:  begin res_w = old_w + rs2_w;  res_d = old_data + rs2; end
         AMO_AND:  begin res_w = old_w & rs2_w;  res_d = old_data & rs2; end
         AMO_OR:   begin res_w = old_w | rs2_w;  res_d = old_data | rs2; end
         AMO_XOR:  begin res_w = old_w ^ rs2_w;  res_d = old_data ^ rs2; end
         AMO_MAX: begin
            res_w = ($signed(old_w) > $signed(rs2_w)) ? old_w : rs2_w;
            res_d = ($signed(old_data) > $signed(rs2)) ? old_data : rs2;
         end
         AMO_MIN: begin
            res_w = ($signed(old_w) < $signed(rs2_w)) ? old_w : rs2_w;
            res_d = ($signed(old_data) < $signed(rs2)) ? old_data : rs2;
         end
         AMO_MAXU: begin
            res_w = (old_w > rs2_w) ? old_w : rs2_w;
            res_d = (old_data > rs2) ? old_data : rs2;
         end
         AMO_MINU: begin
            res_w = (old_w < rs2_w) ? old_w : rs2_w;
            res_d = (old_data < rs2) ? old_data : rs2;
         end
         default: begin res_w = rs2_w; res_d = rs2; end
      endcase
      // Word result is replicated; the byte mask keeps only the addressed lane.
      new_data  = is_word ? {res_w, res_w} : res_d;
      byte_mask = is_word ? (lane ? 8'hF0 : 8'h0F) : 8'hFF;
   end

endmodule

// File: rtl/rvh_l1d_amo_exec_ctrl.sv
// Sequencer for one LR/SC/AMO: bank read, ALU, bank write, ROB writeback.
module rvh_l1d_amo_exec_ctrl
   import rvh_l1d_pkg::*;
#(
   parameter int ALU_REG_STAGE = 1
) (
   input logic                    clk,
   input logic                    rst,
   rvh_l1d_amo_exec_ctrl_if.master bus
);

   amo_state_e                state;
   logic                      rdy_q, rd_vld_q, wr_vld_q, wb_vld_q;
   amo_dec_t                  dec_q;
   logic [ROB_TAG_WIDTH-1:0]  rob_tag_q;
   logic [PREG_TAG_WIDTH-1:0] prd_q;
   logic [PADDR_WIDTH-1:0]    paddr_q;
   logic [XLEN-1:0]           rs2_q, old_q, wr_data_q, wb_data_q;
   logic [XLEN/8-1:0]         wr_mask_q;
   logic [XLEN-1:0]           alu_data;
   logic [XLEN/8-1:0]         alu_mask;
   amo_dec_t                  req_dec;
   logic [PADDR_WIDTH-1:0]    dw_paddr;

   assign req_dec  = amo_decode(bus.stb_amo_req_opcode_i);
   assign dw_paddr = {paddr_q[PADDR_WIDTH-1:3], 3'b000};

   rvh_l1d_amo_alu u_alu (
      .old_data  (old_q),
      .rs2       (rs2_q),
      .alu_op    (dec_q.alu_op),
      .is_word   (dec_q.is_word),
      .lane      (paddr_q[2]),
      .new_data  (alu_data),
      .byte_mask (alu_mask)
   );

   // Main FSM; every handshake valid/ready is a flop updated on transitions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rdy_q    <= 1'b1;
         rd_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
         wb_vld_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.stb_amo_req_vld_i && rdy_q) begin
                  dec_q     <= req_dec;
                  rob_tag_q <= bus.stb_amo_req_rob_tag_i;
                  prd_q     <= bus.stb_amo_req_prd_i;
                  paddr_q   <= bus.stb_amo_req_paddr_i;
                  rs2_q     <= bus.stb_amo_req_data_i;
                  rdy_q     <= 1'b0;
                  if (req_dec.is_sc && !bus.stb_amo_req_sc_succ_i) begin
                     // Lost reservation: no bank access, report failure at once.
                     wb_data_q <= XLEN'(1);
                     wb_vld_q  <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     rd_vld_q <= 1'b1;
                     state    <= S_RD_REQ;
                  end
               end
            end
            S_RD_REQ: begin
               if (bus.bank_rd_req_rdy_i) begin
                  rd_vld_q <= 1'b0;
                  state    <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (bus.bank_rd_resp_vld_i) begin
                  old_q     <= bus.bank_rd_resp_data_i;
                  wb_data_q <= dec_q.is_sc ? XLEN'(0)
                             : load_val(bus.bank_rd_resp_data_i, dec_q.is_word, paddr_q[2]);
                  if (dec_q.is_lr) begin
                     wb_vld_q <= 1'b1;
                     state    <= S_RESP;
                  end else if (ALU_REG_STAGE != 0) begin
                     state <= S_ALU;
                  end else begin
                     wr_vld_q <= 1'b1;
                     state    <= S_WR_REQ;
                  end
               end
            end
            S_ALU: begin
               wr_data_q <= alu_data;
               wr_mask_q <= alu_mask;
               wr_vld_q  <= 1'b1;
               state     <= S_WR_REQ;
            end
            S_WR_REQ: begin
               if (bus.bank_wr_req_rdy_i) begin
                  wr_vld_q <= 1'b0;
                  wb_vld_q <= 1'b1;
                  state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.amo_rob_wb_rdy_i) begin
                  wb_vld_q <= 1'b0;
                  rdy_q    <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               rdy_q    <= 1'b1;
               rd_vld_q <= 1'b0;
               wr_vld_q <= 1'b0;
               wb_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stb_amo_req_rdy_o       = rdy_q;
   assign bus.bank_rd_req_vld_o       = rd_vld_q;
   assign bus.bank_rd_req_paddr_o     = dw_paddr;
   assign bus.bank_wr_req_vld_o       = wr_vld_q;
   assign bus.bank_wr_req_paddr_o     = dw_paddr;
   // Without the register stage old_q and rs2_q are stable in WR_REQ, so the
   // combinational ALU output is itself stable while the write waits.
   assign bus.bank_wr_req_data_o      = (ALU_REG_STAGE != 0) ? wr_data_q : alu_data;
   assign bus.bank_wr_req_byte_mask_o = (ALU_REG_STAGE != 0) ? wr_mask_q : alu_mask;
   assign bus.amo_rob_wb_vld_o        = wb_vld_q;
   assign bus.amo_rob_wb_rob_tag_o    = rob_tag_q;
   assign bus.amo_rob_wb_prd_o        = prd_q;
   assign bus.amo_rob_wb_data_o       = wb_data_q;
   assign bus.busy_o                  = (state != S_IDLE);
   assign bus.dbg_state_o             = state;

endmodule

// File: doc/rvh_l1d_amo_exec_ctrl.md
Name: rvh_l1d_amo_exec_ctrl

Overview:
Bank-side sequencer that executes one atomic request (LR/SC/AMO*) handed over from the store buffer after the STB has drained. Issues a read to the L1D data bank, computes the read-modify-write result, issues the write, then returns the old value (or SC status) to the ROB writeback port. One request is in flight at a time; the store-buffer port is held not-ready while busy.

Parameters:
ALU_REG_STAGE, 1, 1 = register the ALU result before the write request (adds 1 cycle); 0 = issue the write from the combinational ALU result.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stb_amo_req_vld_i  in  1  atomic request valid
stb_amo_req_rob_tag_i  in  ROB_TAG_WIDTH  ROB tag
stb_amo_req_prd_i  in  PREG_TAG_WIDTH  destination physical register
stb_amo_req_opcode_i  in  STU_OP_WIDTH  STU_LR*/SC*/AMO* opcode
stb_amo_req_paddr_i  in  PADDR_WIDTH  physical address; W ops are 4B-aligned, D ops 8B-aligned
stb_amo_req_data_i  in  XLEN  rs2 operand
stb_amo_req_sc_succ_i  in  1  reservation check result; sampled with an SC request
stb_amo_req_rdy_o  out  1  high only in IDLE
bank_rd_req_vld_o  out  1  bank read request
bank_rd_req_paddr_o  out  PADDR_WIDTH  doubleword-aligned address (paddr[2:0] = 0)
bank_rd_req_rdy_i  in  1  bank accepts the read
bank_rd_resp_vld_i  in  1  read data valid
bank_rd_resp_data_i  in  XLEN  doubleword read data
bank_wr_req_vld_o  out  1  bank write request
bank_wr_req_paddr_o  out  PADDR_WIDTH  doubleword-aligned address
bank_wr_req_data_o  out  XLEN  merged write data
bank_wr_req_byte_mask_o  out  XLEN/8  byte enables
bank_wr_req_rdy_i  in  1  bank accepts the write
amo_rob_wb_vld_o  out  1  writeback valid
amo_rob_wb_rob_tag_o  out  ROB_TAG_WIDTH  tag
amo_rob_wb_prd_o  out  PREG_TAG_WIDTH  destination register
amo_rob_wb_data_o  out  XLEN  result
amo_rob_wb_rdy_i  in  1  ROB writeback accepted
busy_o  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation): FSM goes to IDLE and the in-flight request is dropped. All vld outputs and busy_o = 0; stb_amo_req_rdy_o = 1.
- FSM states and transitions:
  - IDLE: rdy = 1. On req handshake, latch opcode/tags/paddr/data/sc_succ.
    - SC with sc_succ = 0 -> RESP with wb_data = 1.
    - All other requests -> RD_REQ.
  - RD_REQ: rd_req_vld = 1; on rdy -> RD_WAIT.
  - RD_WAIT: on rd_resp_vld, latch old doubleword.
    - LR -> RESP, wb_data = loaded value.
    - SC (succ) -> WR_REQ (or ALU if ALU_REG_STAGE = 1).
    - AMO -> ALU (if ALU_REG_STAGE = 1) else WR_REQ.
  - ALU: one cycle, registers the result -> WR_REQ.
  - WR_REQ: wr_req_vld = 1; on rdy -> RESP.
  - RESP: wb_vld = 1.
    - AMO: wb_data = old value.
    - Successful SC: wb_data = 0.
    - Failed SC: wb_data = 1.
    - On wb_rdy -> IDLE. The next request may be accepted in the following cycle, never in the same cycle.
- rd_resp_vld outside RD_WAIT is ignored. All outputs are held stable while vld is high and rdy is low.
- Word ops: operate on lane paddr[2] (0 = [31:0], 1 = [63:32]).
  - Byte mask: 8'h0F or 8'hF0. Other lane of write data is don't-care.
  - Old value is sign-extended from 32 bits for wb.
- D ops: full 64 bits, byte mask 8'hFF.
- ALU (results truncated to operand width, no overflow flag):
  - SWAP = rs2; ADD wraps modulo 2^32 or 2^64.
  - AND/OR/XOR bitwise.
  - MAX/MIN signed compare; MAXU/MINU unsigned compare.
  - SC write data = rs2.
- Latency, handshake to wb_vld, all rdy = 1, bank read latency 1:
  - AMO: 5 cycles with ALU_REG_STAGE = 1, 4 with ALU_REG_STAGE = 0.
  - LR: 3 cycles.
  - Failed SC: 1 cycle.
- paddr[1:0] are ignored; alignment is checked upstream. Unknown opcode is treated as LR (no write).

Decomposition:
- rvh_l1d_pkg: amo_alu_op_e enum (SWAP, ADD, AND, OR, XOR, MAX, MIN, MAXU, MINU), opcode->alu_op/is_word/is_lr/is_sc decode function, FSM state typedef.
- Sub-module rvh_l1d_amo_alu: combinational; inputs old/rs2/alu_op/is_word/lane; outputs new doubleword and byte mask.

Test Plan:
- AMOADDD, rs2 = 64'h1, memory 64'hFFFF_FFFF_FFFF_FFFF -> write data 64'h0, mask 8'hFF, wb_data 64'hFFFF_FFFF_FFFF_FFFF, wb_vld 5 cycles after handshake.
- AMOMAXW at paddr[2] = 1, memory[63:32] = 32'h8000_0000, rs2 = 32'h1 -> write data[63:32] = 32'h1, mask 8'hF0, wb_data 64'hFFFF_FFFF_8000_0000; repeat with AMOMAXUW -> writes 32'h8000_0000 (unchanged).
- SCD with sc_succ = 0 -> no bank read or write, wb_data 1 next cycle. SCD with sc_succ = 1, rs2 = 64'hAB -> write 64'hAB, wb_data 0.
- LRW, memory[31:0] = 32'h7FFF_FFFF -> no write, wb_data 64'h0000_0000_7FFF_FFFF, stb rdy low until wb_rdy.
- Backpressure: rd/wr/wb rdy held low 3 cycles each -> outputs stable, single read/write/wb each; a spurious rd_resp_vld in RD_REQ is ignored.
- rst asserted in WR_REQ -> next cycle all vld = 0, busy_o = 0, rdy = 1; a new AMOSWAPW then completes normally.
